// File: rtl/y86_pkg.sv
// Shared Y86 encodings: instruction codes, ALU functions, branch/move conditions
// and the condition-code bundle used by the execute stage.
package y86_pkg;
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVL = 4'h2;
    localparam logic [3:0] I_IRMOVL = 4'h3;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_OPL    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;
endpackage

// File: rtl/y86_execute_stage_if.sv
// Decode->execute operands in, execute/memory pipeline register out.
interface y86_execute_stage_if;
    logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
    logic [31:0] in_valA, in_valB, in_valC, in_valP;
    logic        in_pred;
    logic [3:0]  exe_icode, exe_rA, exe_rB;
    logic [31:0] exe_valA, exe_valE, exe_valP;
    logic        exe_wrong_pred, exe_apply_fwd;

    modport master (
        output in_icode, in_ifun, in_rA, in_rB, in_valA, in_valB, in_valC, in_valP, in_pred,
        input  exe_icode, exe_rA, exe_rB, exe_valA, exe_valE, exe_valP, exe_wrong_pred, exe_apply_fwd
    );
    modport slave (
        input  in_icode, in_ifun, in_rA, in_rB, in_valA, in_valB, in_valC, in_valP, in_pred,
        output exe_icode, exe_rA, exe_rB, exe_valA, exe_valE, exe_valP, exe_wrong_pred, exe_apply_fwd
    );
endinterface

// File: rtl/y86_alu.sv
// Combinational ALU computing b <op> a, with the flags an OPl would write to CC.
module y86_alu
    import y86_pkg::*;
(
    input  logic [3:0]  fn,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res,
    output cc_t         flags
);
    always_comb begin
        res      = b + a;
        flags.of = 1'b0;
        case (fn)
            ALU_SUB: res = b - a;
            ALU_AND: res = b & a;
            ALU_XOR: res = b ^ a;
            default: res = b + a;
        endcase
        // Sub is b-a, so overflow keys off b's sign rather than a's.
        if (fn == ALU_SUB)
            flags.of = (a[31] != b[31]) && (res[31] != b[31]);
        else if (fn == ALU_ADD)
            flags.of = (a[31] == b[31]) && (res[31] != b[31]);
        flags.zf = (res == 32'h0);
        flags.sf = res[31];
    end
endmodule

// File: rtl/y86_execute_stage.sv
// Y86 execute stage: ALU, condition evaluation, jXX misprediction detection and
// the execute/memory pipeline register.
module y86_execute_stage
    import y86_pkg::*;
(
    input  logic CLOCK_50,
    input  logic reset,
    y86_execute_stage_if.slave bus
);
    cc_t         cc, alu_flags;
    logic [3:0]  alu_fn;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        cond, valid, fwd_n;
    logic [3:0]  rb_n;

    y86_alu u_alu (.fn(alu_fn), .a(alu_a), .b(alu_b), .res(alu_res), .flags(alu_flags));

    // Conditions see CC as left by the previous OPl, never the current one.
    always_comb begin
        cond = 1'b0;
        case (bus.in_ifun)
            C_ALWAYS: cond = 1'b1;
            C_LE:     cond = (cc.sf ^ cc.of) | cc.zf;
            C_L:      cond = cc.sf ^ cc.of;
            C_E:      cond = cc.zf;
            C_NE:     cond = !cc.zf;
            C_GE:     cond = !(cc.sf ^ cc.of);
            C_G:      cond = !(cc.sf ^ cc.of) && !cc.zf;
            default:  cond = 1'b0;
        endcase
    end

    // Non-OPl address/stack arithmetic goes through the ALU as an add.
    always_comb begin
        alu_fn = ALU_ADD;
        alu_a  = 32'h0;
        alu_b  = 32'h0;
        case (bus.in_icode)
            I_RRMOVL:         alu_a = bus.in_valA;
            I_IRMOVL:         alu_a = bus.in_valC;
            I_RMMOVL,
            I_MRMOVL:         begin alu_a = bus.in_valC; alu_b = bus.in_valB; end
            I_OPL:            begin alu_fn = bus.in_ifun; alu_a = bus.in_valA; alu_b = bus.in_valB; end
            I_CALL, I_PUSHL:  begin alu_a = 32'hFFFF_FFFC; alu_b = bus.in_valB; end
            I_RET, I_POPL:    begin alu_a = 32'h0000_0004; alu_b = bus.in_valB; end
            default:          ;
        endcase
    end

    // A mispredicted jXX in the register means the incoming instruction is wrong-path.
    assign valid = (bus.in_icode <= I_POPL) && !bus.exe_wrong_pred;
    assign rb_n  = (bus.in_icode == I_RRMOVL && !cond) ? REG_NONE : bus.in_rB;
    assign fwd_n = ((bus.in_icode == I_IRMOVL) || (bus.in_icode == I_OPL) ||
                    (bus.in_icode == I_RRMOVL && cond)) && (rb_n != REG_NONE);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bus.exe_icode      <= I_NOP;
            bus.exe_rA         <= REG_NONE;
            bus.exe_rB         <= REG_NONE;
            bus.exe_valA       <= 32'h0;
            bus.exe_valE       <= 32'h0;
            bus.exe_valP       <= 32'h0;
            bus.exe_wrong_pred <= 1'b0;
            bus.exe_apply_fwd  <= 1'b0;
            cc                 <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else if (!valid) begin
            bus.exe_icode      <= I_NOP;
            bus.exe_rA         <= REG_NONE;
            bus.exe_rB         <= REG_NONE;
            bus.exe_valA       <= 32'h0;
            bus.exe_valE       <= 32'h0;
            bus.exe_valP       <= bus.in_valP;
            bus.exe_wrong_pred <= 1'b0;
            bus.exe_apply_fwd  <= 1'b0;
        end else begin
            bus.exe_icode      <= bus.in_icode;
            bus.exe_rA         <= bus.in_rA;
            bus.exe_rB         <= rb_n;
            bus.exe_valA       <= bus.in_valA;
            bus.exe_valE       <= alu_res;
            bus.exe_valP       <= (bus.in_icode == I_JXX && cond) ? bus.in_valC : bus.in_valP;
            bus.exe_wrong_pred <= (bus.in_icode == I_JXX) && (cond != bus.in_pred);
            bus.exe_apply_fwd  <= fwd_n;
            if (bus.in_icode == I_OPL)
                cc <= alu_flags;
        end
    end
endmodule

// File: tb/tb_y86_execute_stage.sv
// Table-driven bench for the Y86 execute stage with an expected-result queue.
module tb_y86_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    y86_execute_stage_if bus ();
    y86_execute_stage dut (.CLOCK_50(clk), .reset(rst), .bus(bus));

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [31:0] vala, valb, valc, valp;
        logic        pred;
        logic [3:0]  e_icode, e_rb;
        logic [31:0] e_vale, e_valp;
        logic        e_wp, e_fwd;
    } vec_t;

    vec_t tab[$];
    vec_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] vc, input logic [31:0] vp, input logic pr,
                       input logic [3:0] eic, input logic [3:0] erb, input logic [31:0] eve,
                       input logic [31:0] evp, input logic ewp, input logic efw);
        vec_t v;
        v.icode = ic; v.ifun = fn; v.ra = ra; v.rb = rb;
        v.vala = va; v.valb = vb; v.valc = vc; v.valp = vp; v.pred = pr;
        v.e_icode = eic; v.e_rb = erb; v.e_vale = eve; v.e_valp = evp;
        v.e_wp = ewp; v.e_fwd = efw;
        tab.push_back(v);
    endtask

    // Drive at the falling edge, compare 1 time unit after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        bus.in_icode = v.icode; bus.in_ifun = v.ifun; bus.in_rA = v.ra; bus.in_rB = v.rb;
        bus.in_valA = v.vala; bus.in_valB = v.valb; bus.in_valC = v.valc;
        bus.in_valP = v.valp; bus.in_pred = v.pred;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".icode"}, 32'(bus.exe_icode), 32'(e.e_icode));
        chk({tag, ".rB"},    32'(bus.exe_rB),    32'(e.e_rb));
        chk({tag, ".valE"},  bus.exe_valE,       e.e_vale);
        chk({tag, ".valP"},  bus.exe_valP,       e.e_valp);
        chk({tag, ".wp"},    32'(bus.exe_wrong_pred), 32'(e.e_wp));
        chk({tag, ".fwd"},   32'(bus.exe_apply_fwd),  32'(e.e_fwd));
    endtask

    initial begin
        vec_t v;
        bus.in_icode = 4'h1; bus.in_ifun = 4'h0; bus.in_rA = 4'hF; bus.in_rB = 4'hF;
        bus.in_valA = 32'h0; bus.in_valB = 32'h0; bus.in_valC = 32'h0;
        bus.in_valP = 32'h0; bus.in_pred = 1'b0;

        //   icode fn   rA    rB    valA          valB          valC       valP       pr    eic   erB   valE          valP       wp    fwd
        add(4'h7,4'h3,4'hF,4'hF,32'h0,        32'h0,        32'h40,   32'h20,   1'b0, 4'h7,4'hF,32'h0,        32'h40,   1'b1,1'b0); // je, ZF=1 from reset
        add(4'h3,4'h0,4'hF,4'h3,32'h0,        32'h0,        32'h11,   32'h26,   1'b0, 4'h1,4'hF,32'h0,        32'h26,   1'b0,1'b0); // squashed
        add(4'h6,4'h1,4'h1,4'h2,32'h5,        32'h5,        32'h0,    32'h30,   1'b0, 4'h6,4'h2,32'h0,        32'h30,   1'b0,1'b1); // sub 5-5
        add(4'h7,4'h3,4'hF,4'hF,32'h0,        32'h0,        32'h40,   32'h20,   1'b0, 4'h7,4'hF,32'h0,        32'h40,   1'b1,1'b0);
        add(4'h6,4'h0,4'h1,4'h2,32'h1,        32'h7FFFFFFF, 32'h0,    32'h32,   1'b0, 4'h1,4'hF,32'h0,        32'h32,   1'b0,1'b0); // squashed OPl
        add(4'h7,4'h3,4'hF,4'hF,32'h0,        32'h0,        32'h40,   32'h22,   1'b1, 4'h7,4'hF,32'h0,        32'h40,   1'b0,1'b0); // ZF kept
        add(4'h6,4'h0,4'h1,4'h3,32'h1,        32'h7FFFFFFF, 32'h0,    32'h34,   1'b0, 4'h6,4'h3,32'h80000000, 32'h34,   1'b0,1'b1); // add ovf
        add(4'h2,4'h2,4'h1,4'h4,32'h55,       32'h0,        32'h0,    32'h42,   1'b0, 4'h2,4'hF,32'h55,       32'h42,   1'b0,1'b0); // cmovl false
        add(4'h7,4'h1,4'hF,4'hF,32'h0,        32'h0,        32'h60,   32'h50,   1'b0, 4'h7,4'hF,32'h0,        32'h50,   1'b0,1'b0); // jle false
        add(4'h7,4'h6,4'hF,4'hF,32'h0,        32'h0,        32'h60,   32'h52,   1'b1, 4'h7,4'hF,32'h0,        32'h60,   1'b0,1'b0); // jg true
        add(4'h3,4'h0,4'hF,4'h3,32'h0,        32'h0,        32'h1234, 32'h58,   1'b0, 4'h3,4'h3,32'h1234,     32'h58,   1'b0,1'b1); // irmovl
        add(4'h5,4'h0,4'h1,4'h2,32'h0,        32'h100,      32'h8,    32'h5E,   1'b0, 4'h5,4'h2,32'h108,      32'h5E,   1'b0,1'b0); // mrmovl
        add(4'hA,4'h0,4'h1,4'h4,32'h9,        32'h200,      32'h0,    32'h60,   1'b0, 4'hA,4'h4,32'h1FC,      32'h60,   1'b0,1'b0); // pushl
        add(4'hB,4'h0,4'h1,4'h4,32'h0,        32'h200,      32'h0,    32'h62,   1'b0, 4'hB,4'h4,32'h204,      32'h62,   1'b0,1'b0); // popl
        add(4'h7,4'h4,4'hF,4'hF,32'h0,        32'h0,        32'h70,   32'h64,   1'b1, 4'h7,4'hF,32'h0,        32'h70,   1'b0,1'b0); // jne, CC intact
        add(4'h6,4'h3,4'h1,4'h5,32'hF0,       32'hFF,       32'h0,    32'h6A,   1'b0, 4'h6,4'h5,32'h0F,       32'h6A,   1'b0,1'b1); // xor
        add(4'h2,4'h5,4'h1,4'h6,32'h77,       32'h0,        32'h0,    32'h6C,   1'b0, 4'h2,4'h6,32'h77,       32'h6C,   1'b0,1'b1); // cmovge true
        add(4'h6,4'h1,4'h1,4'h7,32'h1,        32'h80000000, 32'h0,    32'h6E,   1'b0, 4'h6,4'h7,32'h7FFFFFFF, 32'h6E,   1'b0,1'b1); // sub ovf
        add(4'h7,4'h2,4'hF,4'hF,32'h0,        32'h0,        32'h80,   32'h70,   1'b0, 4'h7,4'hF,32'h0,        32'h80,   1'b1,1'b0); // jl true
        add(4'h0,4'h0,4'hF,4'hF,32'h0,        32'h0,        32'h0,    32'h76,   1'b0, 4'h1,4'hF,32'h0,        32'h76,   1'b0,1'b0); // squashed halt
        add(4'h0,4'h0,4'hF,4'hF,32'h0,        32'h0,        32'h0,    32'h77,   1'b0, 4'h0,4'hF,32'h0,        32'h77,   1'b0,1'b0); // halt
        add(4'hC,4'h0,4'h1,4'h2,32'h3,        32'h4,        32'h5,    32'h78,   1'b0, 4'h1,4'hF,32'h0,        32'h78,   1'b0,1'b0); // undefined
        add(4'h6,4'h2,4'h1,4'h2,32'hF0,       32'h0F,       32'h0,    32'h7A,   1'b0, 4'h6,4'h2,32'h0,        32'h7A,   1'b0,1'b1); // and
        add(4'h7,4'h7,4'hF,4'hF,32'h0,        32'h0,        32'hA0,   32'h90,   1'b1, 4'h7,4'hF,32'h0,        32'h90,   1'b1,1'b0); // ifun 7 false
        add(4'h3,4'h0,4'hF,4'h3,32'h0,        32'h0,        32'h5,    32'h96,   1'b0, 4'h1,4'hF,32'h0,        32'h96,   1'b0,1'b0); // squashed
        add(4'h6,4'h1,4'h1,4'hF,32'h1,        32'h3,        32'h0,    32'h9C,   1'b0, 4'h6,4'hF,32'h2,        32'h9C,   1'b0,1'b0); // OPl, rB none
        add(4'h7,4'h3,4'hF,4'hF,32'h0,        32'h0,        32'hB0,   32'hA0,   1'b0, 4'h7,4'hF,32'h0,        32'hA0,   1'b0,1'b0); // je false

        #12;
        chk("reset.icode", 32'(bus.exe_icode), 32'h1);
        chk("reset.rB",    32'(bus.exe_rB),    32'hF);
        chk("reset.valP",  bus.exe_valP,       32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tab.size(); i++)
            apply(tab[i], $sformatf("row%0d", i));

        // Reset mid-run: outputs must drop without waiting for a clock edge.
        v = tab[10];
        v.valc = 32'h99; v.e_vale = 32'h99;
        apply(v, "pre_rst");
        chk("pre_rst.valA", bus.exe_valA, 32'h0);
        rst = 1'b1;
        #1;
        chk("midrst.icode", 32'(bus.exe_icode), 32'h1);
        chk("midrst.rB",    32'(bus.exe_rB),    32'hF);
        chk("midrst.valE",  bus.exe_valE,       32'h0);
        chk("midrst.wp",    32'(bus.exe_wrong_pred), 32'h0);
        chk("midrst.fwd",   32'(bus.exe_apply_fwd),  32'h0);
        @(negedge clk);
        rst = 1'b0;
        // ZF was 0 before the reset; je taken proves reset restored ZF=1.
        v = tab[0];
        v.valc = 32'h44; v.valp = 32'h11; v.e_valp = 32'h44;
        apply(v, "post_rst_je");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
